// File: rtl/cp0_interrupt_unit.sv
// ---------------------------------------------------------------------------
// cp0_interrupt_unit
//
// Coprocessor-0 for the pipelined MIPS core. It holds the Status, Cause, EPC
// and handler Vector registers. It synchronizes the external interrupt line
// and arbitrates the request against the global gate and pipeline stalls. It
// produces a one-cycle redirect (jump_en_o / jump_addr_o) on interrupt entry
// and on eret. The control unit uses that redirect to flush ID.
//
// Optional feature (macro CP0_TIMER_EN): reg 9 Count, reg 11 Compare, and a
// timer pending bit in Cause[15] that can also raise the interrupt.
//
// Handshake note: there is no valid/ready pair here. Every input is sampled
// at the rising clock edge when en_i = 1. jump_en_o is a single-cycle strobe
// with no back-pressure, and jump_addr_o is meaningful only while it is high.
//
// Ports
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   en_i         stage enable; 0 freezes architectural state and the FSM
//   int_type_i   00 none, 01 mfc0, 10 mtc0, 11 eret
//   ir_en_i      global interrupt gate
//   hold_i       stall / branch flush in progress
//   ir_in_i      external interrupt request (asynchronous level)
//   cp0_addr_i   register index
//   wdata_i      mtc0 write data
//   ret_addr_i   resume PC, captured into EPC when an interrupt is taken
//   rdata_o      mfc0 read data (combinational)
//   jump_en_o    one-cycle redirect strobe
//   jump_addr_o  redirect target
//   in_isr_o     handler active
//   state_o      FSM state (debug visibility)
// ---------------------------------------------------------------------------
module cp0_interrupt_unit #(
    parameter logic [31:0] VECTOR_RST  = 32'h0000_0004,
    parameter int          SYNC_STAGES = 2            // legal range 2..3
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en_i,
    input  logic [1:0]  int_type_i,
    input  logic        ir_en_i,
    input  logic        hold_i,
    input  logic        ir_in_i,
    input  logic [4:0]  cp0_addr_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] ret_addr_i,
    output logic [31:0] rdata_o,
    output logic        jump_en_o,
    output logic [31:0] jump_addr_o,
    output logic        in_isr_o,
    output logic [1:0]  state_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ENTER  = 2'd1,
        S_ISR    = 2'd2,
        S_RETURN = 2'd3
    } state_e;

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_prev_q;
    logic                   edge_held_q, edge_held_d;
    logic                   pending_q, pending_d;
    logic [31:0]            status_q, status_d;
    logic [31:0]            epc_q, epc_d;
    logic [31:0]            vector_q, vector_d;

    logic        sync_edge;
    logic        irq_edge;
    logic        timer_pend;
    logic        irq_pend;
    logic        mtc0_we;
    logic        eret_act;
    logic        take;
    logic        take_fire;
    logic [31:0] cause_val;

    // -----------------------------------------------------------------------
    // Decode
    // -----------------------------------------------------------------------
    assign mtc0_we  = en_i & (int_type_i == 2'b10);
    assign eret_act = en_i & ~hold_i & (int_type_i == 2'b11);
    assign irq_pend = pending_q | timer_pend;
    assign take     = irq_pend & status_q[0] & ir_en_i & ~hold_i & en_i &
                      (state_q == S_IDLE);
    // An eret decoded in IDLE wins over a simultaneous take. The request
    // stays pending and is taken after the return completes.
    assign take_fire = take & ~eret_act;

    // -----------------------------------------------------------------------
    // Synchronizer and edge detection. The flops run regardless of en_i.
    // An edge seen while disabled is latched in edge_held_q so that it is
    // registered once the stage is enabled again.
    // -----------------------------------------------------------------------
    assign sync_edge = sync_q[SYNC_STAGES-1] & ~sync_prev_q;
    assign irq_edge  = sync_edge | edge_held_q;

    always_comb begin
        edge_held_d = en_i ? 1'b0 : (edge_held_q | sync_edge);
        pending_d   = pending_q;
        if (en_i) begin
            if (irq_edge) begin
                pending_d = 1'b1;
            end else if (take_fire) begin
                pending_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q      <= '0;
            sync_prev_q <= 1'b0;
            edge_held_q <= 1'b0;
            pending_q   <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], ir_in_i};
            sync_prev_q <= sync_q[SYNC_STAGES-1];
            edge_held_q <= edge_held_d;
            pending_q   <= pending_d;
        end
    end

    // -----------------------------------------------------------------------
    // Optional timer
    // -----------------------------------------------------------------------
`ifdef CP0_TIMER_EN
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        tip_q, tip_d;

    always_comb begin
        count_d   = count_q;
        compare_d = compare_q;
        tip_d     = tip_q;
        if (en_i) begin
            count_d = count_q + 32'd1;
            if ((count_q == compare_q) && (compare_q != 32'd0)) begin
                tip_d = 1'b1;
            end
            // A Compare write acknowledges the timer, even on a match cycle.
            if (mtc0_we && (cp0_addr_i == 5'd11)) begin
                compare_d = wdata_i;
                tip_d     = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q   <= '0;
            compare_q <= '0;
            tip_q     <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            tip_q     <= tip_d;
        end
    end

    assign timer_pend = tip_q;
`else
    assign timer_pend = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Architectural registers
    // -----------------------------------------------------------------------
    always_comb begin
        status_d = status_q;
        epc_d    = epc_q;
        vector_d = vector_q;
        if (mtc0_we) begin
            case (cp0_addr_i)
                5'd12:   status_d = wdata_i;
                5'd14:   epc_d    = wdata_i;
                5'd15:   vector_d = wdata_i;
                default: ;
            endcase
        end
        // Hardware updates of IE and EPC take priority over a software write
        // in the same cycle.
        if (take_fire) begin
            epc_d       = ret_addr_i;
            status_d[0] = 1'b0;
        end
        if (en_i && (state_q == S_RETURN)) begin
            status_d[0] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            status_q <= '0;
            epc_q    <= '0;
            vector_q <= VECTOR_RST;
        end else begin
            status_q <= status_d;
            epc_q    <= epc_d;
            vector_q <= vector_d;
        end
    end

    // -----------------------------------------------------------------------
    // Read mux
    // -----------------------------------------------------------------------
    assign cause_val = {16'h0, timer_pend, 6'h0, pending_q, 8'h0};

    always_comb begin
        rdata_o = '0;
        if (int_type_i == 2'b01) begin
            case (cp0_addr_i)
`ifdef CP0_TIMER_EN
                5'd9:    rdata_o = count_q;
                5'd11:   rdata_o = compare_q;
`endif
                5'd12:   rdata_o = status_q;
                5'd13:   rdata_o = cause_val;
                5'd14:   rdata_o = epc_q;
                5'd15:   rdata_o = vector_q;
                default: rdata_o = '0;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // FSM: state register / next state / outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (en_i) begin
            case (state_q)
                S_IDLE: begin
                    if (eret_act) begin
                        state_d = S_RETURN;
                    end else if (take) begin
                        state_d = S_ENTER;
                    end
                end
                S_ENTER:  state_d = S_ISR;
                S_ISR: begin
                    if (eret_act) begin
                        state_d = S_RETURN;
                    end
                end
                S_RETURN: state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    // The outputs decode the state register directly, so an asynchronous
    // reset during ENTER/RETURN drops the strobe immediately.
    always_comb begin
        jump_en_o   = 1'b0;
        jump_addr_o = '0;
        in_isr_o    = 1'b0;
        case (state_q)
            S_ENTER: begin
                jump_en_o   = 1'b1;
                jump_addr_o = vector_q;
            end
            S_RETURN: begin
                jump_en_o   = 1'b1;
                jump_addr_o = epc_q;
            end
            S_ISR:   in_isr_o = 1'b1;
            default: ;
        endcase
    end

    assign state_o = state_q;

endmodule
